// File: rtl/jescpu_pkg.sv
// jescpu_pkg: shared definitions for the jescpu_core memory-to-memory CPU.
//   - opcode constants and NUM_OPS (first illegal opcode value)
//   - state_t: 4-bit state encoding, also exported on dbg_state
//   - instr_len(): instruction length in words; JMP is 0 because it loads pc
package jescpu_pkg;

  localparam int OP_NOP  = 0;
  localparam int OP_COPY = 1;
  localparam int OP_ADD  = 2;
  localparam int OP_SUB  = 3;
  localparam int OP_XOR  = 4;
  localparam int OP_AND  = 5;
  localparam int OP_OR   = 6;
  localparam int OP_NOT  = 7;
  localparam int OP_JMP  = 8;
  localparam int OP_JZ   = 9;
  localparam int OP_OUT  = 10;
  localparam int OP_IN   = 11;
  localparam int NUM_OPS = 12;

  typedef enum logic [3:0] {
    S_NOTREADY = 4'h0,
    S_PREFETCH = 4'h1,
    S_OPCODE   = 4'h2,
    S_OP1      = 4'h3,
    S_OP2      = 4'h4,
    S_IND1     = 4'h5,
    S_IND2     = 4'h6,
    S_EXEC     = 4'h7,
    S_WAIT     = 4'h8,
    S_HALT     = 4'hF
  } state_t;

  // Only legal opcodes reach this, so the low 4 bits identify the instruction.
  function automatic logic [1:0] instr_len(input logic [3:0] opcode);
    logic [1:0] len;
    case (opcode)
      4'(OP_NOP): len = 2'd1;
      4'(OP_NOT): len = 2'd2;
      4'(OP_JMP): len = 2'd0;
      default:    len = 2'd3;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/jescpu_alu.sv
// jescpu_alu: combinational data path for the memory-writing instructions.
// Ports:
//   opcode  in  DW  current instruction opcode
//   value1  in  DW  m[a]
//   value2  in  DW  m[b]
//   result  out DW  value to be written back to m[a]
// Covers COPY/ADD/SUB/XOR/AND/OR/NOT; anything else yields 0.
module jescpu_alu
  import jescpu_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] opcode,
  input  logic [DW-1:0] value1,
  input  logic [DW-1:0] value2,
  output logic [DW-1:0] result
);

  // Arithmetic wraps modulo 2^DW; no flags are produced.
  always_comb begin
    result = '0;
    case (opcode)
      DW'(OP_COPY): result = value2;
      DW'(OP_ADD):  result = value1 + value2;
      DW'(OP_SUB):  result = value1 - value2;
      DW'(OP_XOR):  result = value1 ^ value2;
      DW'(OP_AND):  result = value1 & value2;
      DW'(OP_OR):   result = value1 | value2;
      DW'(OP_NOT):  result = ~value1;
      default:      result = '0;
    endcase
  end

endmodule

// File: rtl/jescpu_core.sv
// jescpu_core: parametrised memory-to-memory CPU talking to a synchronous
// single-port RAM (read data valid one cycle after the address).
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   run, step          only with JESCPU_STEP_EN: run=0 makes PREFETCH wait
//                      for a single-cycle step pulse
//   mem_addr/we/wdata  RAM address, one-cycle write strobe, write data
//   mem_rdata          RAM read data
//   in_data/out_data   NPORTS packed DW-bit IN ports / OUT port registers
//   halted             set once an illegal opcode has been fetched
//   dbg_pc/opcode/state debug taps for the board LED scanner
// Optional feature macro: JESCPU_STEP_EN (single-step control).
module jescpu_core
  import jescpu_pkg::*;
#(
  parameter int DW          = 8,
  parameter int AW          = 8,
  parameter int WAIT_CYCLES = 1,
  parameter int NPORTS      = 4,
  parameter int READY_DELAY = 48
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef JESCPU_STEP_EN
  input  logic                 run,
  input  logic                 step,
`endif
  output logic [AW-1:0]        mem_addr,
  output logic                 mem_we,
  output logic [DW-1:0]        mem_wdata,
  input  logic [DW-1:0]        mem_rdata,
  input  logic [NPORTS*DW-1:0] in_data,
  output logic [NPORTS*DW-1:0] out_data,
  output logic                 halted,
  output logic [AW-1:0]        dbg_pc,
  output logic [DW-1:0]        dbg_opcode,
  output logic [3:0]           dbg_state
);

  localparam int WW = $clog2(WAIT_CYCLES + 1);
  localparam int RW = $clog2(READY_DELAY + 2);
  localparam logic [WW-1:0] WAIT_LOAD = WW'(WAIT_CYCLES - 1);

  state_t          state;
  state_t          ret_state;
  logic [WW-1:0]   wait_cnt;
  logic [RW-1:0]   ready_cnt;
  logic [AW-1:0]   pc;
  logic [DW-1:0]   opcode;
  logic [AW-1:0]   op1;
  logic [DW-1:0]   op2;
  logic [DW-1:0]   val1;
  logic [DW-1:0]   val2;
  logic [DW-1:0]   alu_result;
  logic [DW-1:0]   in_sel;
  logic [AW-1:0]   pc_seq;
  logic            fetch_go;
  logic            leaving;
  logic            is_alu;

`ifdef JESCPU_STEP_EN
  // A step pulse only matters while PREFETCH is holding; elsewhere it is ignored.
  assign fetch_go = run | step;
`else
  assign fetch_go = 1'b1;
`endif

  assign dbg_pc     = pc;
  assign dbg_opcode = opcode;
  assign dbg_state  = state;

  assign pc_seq = pc + AW'(instr_len(opcode[3:0]));
  assign is_alu = (opcode >= DW'(OP_ADD)) && (opcode <= DW'(OP_OR));

  // Every working state is followed by WAIT; PREFETCH only once allowed to fetch.
  assign leaving = (state == S_PREFETCH) ? fetch_go :
                   (state inside {S_OPCODE, S_OP1, S_OP2, S_IND1, S_IND2, S_EXEC});

  // IN port selection; an out-of-range port number leaves the value at 0.
  always_comb begin
    in_sel = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (op2 == DW'(i)) in_sel = in_data[i*DW +: DW];
    end
  end

  jescpu_alu #(.DW(DW)) u_alu (
    .opcode (opcode),
    .value1 (val1),
    .value2 (val2),
    .result (alu_result)
  );

  // Main sequencer: one state per memory access, each followed by a WAIT of
  // WAIT_CYCLES cycles so the RAM read data settles before the next sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_NOTREADY;
      ret_state <= S_NOTREADY;
      wait_cnt  <= '0;
      ready_cnt <= '0;
      pc        <= '0;
      opcode    <= '0;
      op1       <= '0;
      op2       <= '0;
      val1      <= '0;
      val2      <= '0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      out_data  <= '0;
      halted    <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (leaving) begin
        state    <= S_WAIT;
        wait_cnt <= WAIT_LOAD;
      end
      case (state)
        S_NOTREADY: begin
          if (ready_cnt == RW'(READY_DELAY)) state <= S_PREFETCH;
          else ready_cnt <= ready_cnt + RW'(1);
        end
        S_PREFETCH: begin
          if (fetch_go) begin
            mem_addr  <= pc;
            ret_state <= S_OPCODE;
          end
        end
        S_OPCODE: begin
          opcode <= mem_rdata;
          if (mem_rdata >= DW'(NUM_OPS)) begin
            ret_state <= S_HALT;
          end else if (mem_rdata == DW'(OP_NOP)) begin
            pc        <= pc + AW'(instr_len(mem_rdata[3:0]));
            ret_state <= S_PREFETCH;
          end else begin
            mem_addr  <= pc + AW'(1);
            ret_state <= S_OP1;
          end
        end
        S_OP1: begin
          op1 <= mem_rdata[AW-1:0];
          if (opcode == DW'(OP_JMP)) begin
            ret_state <= S_EXEC;
          end else if (opcode == DW'(OP_NOT)) begin
            mem_addr  <= mem_rdata[AW-1:0];
            ret_state <= S_IND1;
          end else begin
            mem_addr  <= pc + AW'(2);
            ret_state <= S_OP2;
          end
        end
        S_OP2: begin
          op2 <= mem_rdata;
          if (opcode == DW'(OP_COPY)) begin
            mem_addr  <= mem_rdata[AW-1:0];
            ret_state <= S_IND2;
          end else if (opcode == DW'(OP_IN)) begin
            ret_state <= S_EXEC;
          end else begin
            mem_addr  <= op1;
            ret_state <= S_IND1;
          end
        end
        S_IND1: begin
          val1 <= mem_rdata;
          if (is_alu) begin
            mem_addr  <= op2[AW-1:0];
            ret_state <= S_IND2;
          end else begin
            ret_state <= S_EXEC;
          end
        end
        S_IND2: begin
          val2      <= mem_rdata;
          ret_state <= S_EXEC;
        end
        S_EXEC: begin
          ret_state <= S_PREFETCH;
          if (opcode == DW'(OP_JMP)) begin
            pc <= op1;
          end else if (opcode == DW'(OP_JZ)) begin
            pc <= (val1 == '0) ? op2[AW-1:0] : pc_seq;
          end else if (opcode == DW'(OP_OUT)) begin
            for (int i = 0; i < NPORTS; i++) begin
              if (op2 == DW'(i)) out_data[i*DW +: DW] <= val1;
            end
            pc <= pc_seq;
          end else begin
            // All remaining legal opcodes write m[a]; the strobe lands in the first WAIT cycle.
            mem_we    <= 1'b1;
            mem_addr  <= op1;
            mem_wdata <= (opcode == DW'(OP_IN)) ? in_sel : alu_result;
            pc        <= pc_seq;
          end
        end
        S_WAIT: begin
          if (wait_cnt == '0) state <= ret_state;
          else wait_cnt <= wait_cnt - WW'(1);
        end
        S_HALT: begin
          halted <= 1'b1;
        end
        default: begin
          state <= S_HALT;
        end
      endcase
    end
  end

endmodule

// File: doc/jescpu_core.md
# jescpu_core

Parametrised memory-to-memory CPU core, the successor to the board-level 8-bit CPU. It is generalised in data width, address width, memory wait states and I/O port count, and gains real IN ports, a defined HALT state and debug taps. It connects to a synchronous single-port RAM. It is instantiated by a board top that owns the RAM and the LED scanner, and the scanner displays the debug taps.

## Interface
- DW, 8: data word width; must be ≥ 4
- AW, 8: address width, AW ≤ DW; operand words use their low AW bits as addresses
- WAIT_CYCLES, 1: wait cycles after every state; must be ≥ 1 (RAM read latency is 1)
- NPORTS, 4: number of OUT ports and number of IN ports
- READY_DELAY, 48: post-reset idle cycles before the first fetch (BRAM start-up)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- mem_addr  out  AW  RAM address
- mem_we  out  1  RAM write enable, one-cycle pulse
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data, valid one cycle after mem_addr
- in_data  in  NPORTS*DW  IN port p occupies bits [p*DW +: DW]
- out_data  out  NPORTS*DW  OUT port registers, same packing
- halted  out  1  core stopped on an illegal opcode
- dbg_pc  out  AW  current PC
- dbg_opcode  out  DW  last fetched opcode
- dbg_state  out  4  current state encoding

## Operation
- Opcodes: NOP=0, COPY=1, ADD=2, SUB=3, XOR=4, AND=5, OR=6, NOT=7, JMP=8, JZ=9, OUT=10, IN=11. Any value ≥ 12 is illegal.
- Semantics, with a and b as operand words:
  - COPY a b: m[a]=m[b]
  - ADD/SUB/XOR/AND/OR a b: m[a]=m[a] op m[b], arithmetic mod 2^DW, no flags
  - NOT a: m[a]=~m[a]
  - JMP a: pc=a
  - JZ a b: pc = (m[a]==0) ? b : pc+3
  - OUT a p: out[p]=m[a]
  - IN a p: m[a]=in[p], sampled in EXEC
- If p ≥ NPORTS, OUT has no effect and IN writes 0. Both still advance pc by 3.
- Instruction length: NOP 1, NOT 2, JMP none (pc loaded), all others 3. PC arithmetic is mod 2^AW and wraps silently.
- States: NOTREADY, PREFETCH, OPCODE, OP1, OP2, IND1, IND2, EXEC, WAIT, HALT.
- State paths:
  - NOP: PREFETCH, OPCODE
  - JMP: PREFETCH, OPCODE, OP1, EXEC
  - NOT: PREFETCH, OPCODE, OP1, IND1, EXEC
  - COPY: PREFETCH, OPCODE, OP1, OP2, IND2, EXEC
  - ALU ops: PREFETCH, OPCODE, OP1, OP2, IND1, IND2, EXEC
  - JZ/OUT: PREFETCH, OPCODE, OP1, OP2, IND1, EXEC
  - IN: PREFETCH, OPCODE, OP1, OP2, EXEC
- Every non-WAIT state is followed by WAIT, which lasts WAIT_CYCLES cycles and then enters the recorded next state.
- An illegal opcode captured in OPCODE moves the core to HALT. HALT sets halted=1, freezes pc at the offending instruction, and is left only by reset.
- Writes: EXEC drives mem_addr, mem_wdata and mem_we=1 for exactly one cycle (the first WAIT cycle). mem_we is 0 in every other cycle.

## Timing
- Reset values: state=NOTREADY, pc=0, mem_addr=0, mem_we=0, mem_wdata=0, out_data=0, halted=0, dbg_opcode=0.
- Reset asserted mid-instruction clears mem_we asynchronously, so an in-flight write is aborted.
- NOTREADY lasts READY_DELAY+1 cycles, then PREFETCH.
- Each state visited costs 1+WAIT_CYCLES cycles. With WAIT_CYCLES=1: NOP 4 cycles, JMP 8, ADD 14.
- A state that samples mem_rdata does so in its own cycle. That data was addressed at least 1+WAIT_CYCLES cycles earlier.
- Self-modifying code: a write in EXEC is visible to the next PREFETCH.

## Configuration
- JESCPU_STEP_EN defined:
  - Adds input run (1 bit) and input step (1 bit, single-cycle pulse).
  - While run=0, PREFETCH holds until step=1, then fetches exactly one instruction.
  - A step pulse arriving mid-instruction is ignored.
- JESCPU_STEP_EN undefined: neither port exists and the core free-runs.

## Structure
- Package jescpu_pkg holds:
  - opcode constants and NUM_OPS
  - state encoding, 4-bit, HALT=4'hF
  - function instr_len(opcode)
- Sub-module jescpu_alu is purely combinational: opcode, value1 and value2 in, DW-bit result out. It covers COPY/ADD/SUB/XOR/AND/OR/NOT.

## Test plan
- ADD: DW=8, m[20]=200, m[21]=100, program "2 20 21" → m[20]=44 (wrapped), pc=3, 14 cycles from PREFETCH with WAIT_CYCLES=1.
- JZ: m[30]=0, program "9 30 40" → pc=40. Repeat with m[30]=5 → pc=3.
- Ports: OUT then IN with NPORTS=4, "10 5 2" with m[5]=0xA5 → out port 2=0xA5. "11 6 3" with in port 3=0x3C → m[6]=0x3C. "10 5 7" → out_data unchanged.
- Halt: opcode 0xFF at address 9 → halted=1, dbg_pc=9, no mem_we pulse for ≥100 cycles.
- Reset: assert rst_n=0 in the mem_we cycle of an ADD → mem_we falls immediately, m[a] is unchanged, and the core restarts at pc=0 after READY_DELAY.
- Step mode (JESCPU_STEP_EN, run=0): three step pulses → exactly three instructions retire. With DW=16, AW=10, WAIT_CYCLES=3: "2 a b" with 0xFFFF+2 → m[a]=1.
